// File: rtl/decoder_pkg.sv
// Shared types and defaults for decoder_scan.
// State encoding plus default select / prescaler widths.
package decoder_pkg;

  localparam int SEL_W_DEF = 3;
  localparam int DIV_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

endpackage

// File: rtl/decoder_scan_onehot.sv
// onehot_dec: combinational index to one-hot map.
// Ports: en (0 forces all-zero), sel index, y one-hot of width 2**SEL_W.
module onehot_dec #(
  parameter int SEL_W = 3
) (
  input  logic                    en,
  input  logic [SEL_W-1:0]        sel,
  output logic [(1<<SEL_W)-1:0]   y
);

  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with direct and auto-scan modes.
// Ports: clk, rst (sync, high), E, mode, A, div -> D, idx, wrap.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W = SEL_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  E,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      A,
  input  logic [DIV_W-1:0]      div,
  output logic [(1<<SEL_W)-1:0] D,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int N = 1 << SEL_W;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic [N-1:0]     d_q, d_d;

  always_comb begin
    state_d = ST_IDLE;
    unique case (1'b1)
      !E:           state_d = ST_IDLE;
      E && !mode:   state_d = ST_DIRECT;
      E && mode:    state_d = ST_SCAN;
    endcase
  end

  // Leaving DIRECT always starts the scan dwell from zero.
  always_comb begin
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    wrap_d   = 1'b0;
    cnt_base = (state_q == ST_DIRECT) ? '0 : cnt_q;
    unique case (state_d)
      ST_DIRECT: begin
        idx_d = A;
        cnt_d = '0;
      end
      ST_SCAN: begin
        // >= so a lowered div ends the current dwell at once.
        if (cnt_base >= div) begin
          cnt_d  = '0;
          idx_d  = idx_q + SEL_W'(1);
          wrap_d = &idx_q;
        end else begin
          cnt_d = cnt_base + DIV_W'(1);
        end
      end
      default: ;
    endcase
  end

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .en  (state_d != ST_IDLE),
    .sel (idx_d),
    .y   (d_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      d_q     <= d_d;
    end
  end

  assign D    = d_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule
